// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Function : Sequential ALU. Single-cycle logic/arith/shift ops plus an
//             N-cycle shift-add multiplier, with registered result and flags.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] result,
    output logic         neg,
    output logic         zero,
    output logic         cout,
    output logic         overflow
);
    localparam int c_cntWidth = $clog2(N);
    localparam logic [c_cntWidth-1:0] c_cntLast = c_cntWidth'(N - 1);
    localparam logic [N-1:0] c_nVal = N'(N);

    localparam logic [3:0] c_opAdd = 4'd0;
    localparam logic [3:0] c_opSub = 4'd1;
    localparam logic [3:0] c_opNot = 4'd2;
    localparam logic [3:0] c_opAnd = 4'd3;
    localparam logic [3:0] c_opOr  = 4'd4;
    localparam logic [3:0] c_opXor = 4'd5;
    localparam logic [3:0] c_opSrl = 4'd6;
    localparam logic [3:0] c_opSll = 4'd7;
    localparam logic [3:0] c_opSra = 4'd8;
    localparam logic [3:0] c_opSla = 4'd9;
    localparam logic [3:0] c_opMul = 4'd10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [2*N-1:0]        r_mcand;
    logic [N-1:0]          r_mplier;
    logic [2*N-1:0]        r_prod;
    logic [c_cntWidth-1:0] r_cnt;

    logic [N-1:0] r_result;
    logic         r_neg;
    logic         r_zero;
    logic         r_cout;
    logic         r_ovf;
    logic         r_done;

    logic           w_accept;
    logic           w_mulLast;
    logic           w_load;
    logic [2*N-1:0] w_prodNext;

    logic [N:0]   w_addSum;
    logic [N:0]   w_subSum;
    logic [N:0]   w_srlExt;
    logic [N:0]   w_sllExt;
    logic [N-1:0] w_sraRes;
    logic         w_slaOvf;

    logic [N-1:0] w_aluRes;
    logic         w_aluCout;
    logic         w_aluOvf;

    logic [N-1:0] w_finRes;
    logic         w_finCout;
    logic         w_finOvf;

    assign ready     = (r_state == IDLE);
    assign w_accept  = (r_state == IDLE) && start;
    assign w_mulLast = (r_state == MUL) && (r_cnt == c_cntLast);
    assign w_load    = (w_accept && (op != c_opMul)) || w_mulLast;

    // One partial product per cycle: multiplicand walks left, multiplier right.
    assign w_prodNext = r_prod + (r_mplier[0] ? r_mcand : '0);

    // ------------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE: begin
                if (start && (op == c_opMul)) begin
                    w_stateNext = MUL;
                end
            end
            MUL: begin
                if (r_cnt == c_cntLast) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------------
    assign w_addSum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign w_subSum = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};

    // Extra guard bit catches the last bit shifted out; it falls to zero
    // automatically once the shift amount exceeds N.
    assign w_srlExt = {a, 1'b0} >> b;
    assign w_sllExt = {1'b0, a} << b;
    assign w_sraRes = $unsigned($signed(a) >>> b);

    // Sign bit is disturbed if any bit passing through it differs from a[N-1];
    // for shifts of N or more, inserted zeros also pass through.
    always_comb begin
        w_slaOvf = 1'b0;
        for (int k = 1; k < N; k++) begin
            if ((b >= N'(k)) && (a[N-1-k] != a[N-1])) begin
                w_slaOvf = 1'b1;
            end
        end
        if ((b >= c_nVal) && a[N-1]) begin
            w_slaOvf = 1'b1;
        end
    end

    always_comb begin
        w_aluRes  = '0;
        w_aluCout = 1'b0;
        w_aluOvf  = 1'b0;
        case (op)
            c_opAdd: begin
                w_aluRes  = w_addSum[N-1:0];
                w_aluCout = w_addSum[N];
                w_aluOvf  = (a[N-1] == b[N-1]) && (w_addSum[N-1] != a[N-1]);
            end
            c_opSub: begin
                w_aluRes  = w_subSum[N-1:0];
                w_aluCout = w_subSum[N];
                w_aluOvf  = (a[N-1] != b[N-1]) && (w_subSum[N-1] != a[N-1]);
            end
            c_opNot: w_aluRes = ~a;
            c_opAnd: w_aluRes = a & b;
            c_opOr:  w_aluRes = a | b;
            c_opXor: w_aluRes = a ^ b;
            c_opSrl: begin
                w_aluRes  = w_srlExt[N:1];
                w_aluCout = w_srlExt[0];
            end
            c_opSra: begin
                w_aluRes  = w_sraRes;
                w_aluCout = w_srlExt[0];
            end
            c_opSll: begin
                w_aluRes  = w_sllExt[N-1:0];
                w_aluCout = w_sllExt[N];
            end
            c_opSla: begin
                w_aluRes  = w_sllExt[N-1:0];
                w_aluCout = w_sllExt[N];
                w_aluOvf  = w_slaOvf;
            end
            default: begin
                w_aluRes  = '0;
                w_aluCout = 1'b0;
                w_aluOvf  = 1'b0;
            end
        endcase
    end

    assign w_finRes  = (r_state == MUL) ? w_prodNext[N-1:0] : w_aluRes;
    assign w_finCout = (r_state == MUL) ? |w_prodNext[2*N-1:N] : w_aluCout;
    assign w_finOvf  = (r_state == MUL) ? 1'b0 : w_aluOvf;

    // ------------------------------------------------------------------------
    // Multiplier registers and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_load;
            if (w_accept && (op == c_opMul)) begin
                r_mcand  <= {{N{1'b0}}, a};
                r_mplier <= b;
                r_prod   <= '0;
                r_cnt    <= '0;
            end else if (r_state == MUL) begin
                r_prod   <= w_prodNext;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= w_mulLast ? '0 : r_cnt + c_cntWidth'(1);
            end
            if (w_load) begin
                r_result <= w_finRes;
                r_neg    <= w_finRes[N-1];
                r_zero   <= (w_finRes == '0);
                r_cout   <= w_finCout;
                r_ovf    <= w_finOvf;
            end
        end
    end

    assign done     = r_done;
    assign result   = r_result;
    assign neg      = r_neg;
    assign zero     = r_zero;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Function : Scoreboard bench for alu_seq (N=8) with a step-wise reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       ready;
    logic       done;
    logic [7:0] result;
    logic       neg;
    logic       zero;
    logic       cout;
    logic       overflow;

    typedef struct packed {
        logic [7:0] res;
        logic       neg;
        logic       zero;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   nChecks = 0;
    int   nErrors = 0;

    alu_seq #(.N(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .neg      (neg),
        .zero     (zero),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: arithmetic on integers; shifts performed one bit at a time.
    function automatic exp_t model(input int o, input int x, input int y, input int c);
        exp_t e;
        int r = 0, co = 0, ov = 0;
        int sx = (x >= 128) ? x - 256 : x;
        int sy = (y >= 128) ? y - 256 : y;
        int v, outb, s;
        case (o)
            0: begin
                s  = x + y + c;
                r  = s % 256;
                co = (s > 255) ? 1 : 0;
                ov = ((sx + sy + c) > 127 || (sx + sy + c) < -128) ? 1 : 0;
            end
            1: begin
                r  = (x - y + 256) % 256;
                co = (x >= y) ? 1 : 0;
                ov = ((sx - sy) > 127 || (sx - sy) < -128) ? 1 : 0;
            end
            2: r = 255 - x;
            3: r = x & y;
            4: r = x | y;
            5: r = x ^ y;
            6, 7, 8, 9: begin
                v = x;
                outb = 0;
                for (int k = 0; k < y; k++) begin
                    if (o == 6 || o == 8) begin
                        outb = v % 2;
                        v = (o == 8) ? ((v / 2) | (v & 128)) : (v / 2);
                    end else begin
                        outb = (v / 128) % 2;
                        v = (v * 2) % 256;
                        if (o == 9 && ((v / 128) % 2) != ((x / 128) % 2)) ov = 1;
                    end
                end
                r  = v;
                co = (y >= 1 && y <= 8) ? outb : 0;
            end
            10: begin
                s  = x * y;
                r  = s % 256;
                co = (s >= 256) ? 1 : 0;
            end
            default: r = 0;
        endcase
        e.res  = 8'(r);
        e.neg  = (r >= 128);
        e.zero = (r == 0);
        e.cout = co[0];
        e.ovf  = ov[0];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending request (result=%0h)", result);
                end else begin
                    e = sb.pop_front();
                    chk("sb_result", 32'(result), 32'(e.res));
                    chk("sb_flags", 32'({neg, zero, cout, overflow}),
                        32'({e.neg, e.zero, e.cout, e.ovf}));
                end
            end
        end
    endtask

    // Waits for ready while throwing junk (including start) at the DUT, then
    // presents one request for exactly one acceptance edge.
    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic c);
        int w = 0;
        while (!ready && w < 100) begin
            start = 1'($urandom_range(0, 1));
            op    = 4'($urandom);
            a     = 8'($urandom);
            b     = 8'($urandom);
            cin   = 1'($urandom);
            @(posedge clk);
            #1;
            w++;
        end
        if (!ready) begin
            nChecks++;
            nErrors++;
            $display("FAIL ready_timeout: got ready=0 expected 1 within 100 cycles");
        end
        op = o; a = x; b = y; cin = c; start = 1'b1;
        sb.push_back(model(int'(o), int'(x), int'(y), int'(c)));
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 4'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    endtask

    task automatic chkOut(input string name, input logic [7:0] r, input logic [3:0] f);
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_res"}, 32'(result), 32'(r));
        chk({name, "_flags"}, 32'({neg, zero, cout, overflow}), 32'(f));
    endtask

    initial begin
        int k, low;
        logic [3:0] ro;
        logic [7:0] ry;
        fork
            monitor();
        join_none

        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({neg, zero, cout, overflow}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // flags packed as {neg, zero, cout, overflow}
        issue(4'd0, 8'h7F, 8'h01, 1'b0); chkOut("add7f", 8'h80, 4'b1001);
        issue(4'd1, 8'h05, 8'h05, 1'b0); chkOut("sub_eq", 8'h00, 4'b0110);
        issue(4'd1, 8'h03, 8'h05, 1'b0); chkOut("sub_lt", 8'hFE, 4'b1000);
        issue(4'd8, 8'h80, 8'd3, 1'b0);  chkOut("sra", 8'hF0, 4'b1000);
        issue(4'd6, 8'h81, 8'd1, 1'b0);  chkOut("srl", 8'h40, 4'b0010);
        issue(4'd9, 8'h40, 8'd1, 1'b0);  chkOut("sla", 8'h80, 4'b1001);
        issue(4'd7, 8'h01, 8'd9, 1'b0);  chkOut("sll9", 8'h00, 4'b0100);

        // MUL latency, with a stray start mid-operation
        issue(4'd10, 8'h10, 8'h11, 1'b0);
        k = 1;
        low = 0;
        while (!done && k < 20) begin
            if (!ready) low++;
            start = (k == 4);
            op    = 4'd0;
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        chk("mul_ready_low", 32'(low), 32'd8);
        chk("mul_done_cycle", 32'(k), 32'd9);
        chkOut("mul", 8'h10, 4'b0010);
        @(posedge clk);
        #1;
        chk("mul_single_done", 32'(done), 32'd0);

        // Reset during iteration 4, colliding with a start
        issue(4'd10, 8'h10, 8'h11, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0; start = 1'b1; op = 4'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; start = 1'b0;
        sb.delete();
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        low = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) low++;
        end
        chk("abort_no_done", 32'(low), 32'd0);
        issue(4'd0, 8'h12, 8'h34, 1'b1); chkOut("post_abort_add", 8'h47, 4'b0000);

        // Back-to-back
        issue(4'd3, 8'hF0, 8'h3C, 1'b0); chk("b2b_done1", 32'(done), 32'd1);
        issue(4'd4, 8'hF0, 8'h0C, 1'b0); chk("b2b_done2", 32'(done), 32'd1);
        issue(4'd12, 8'hAA, 8'h55, 1'b1); chkOut("b2b_invalid", 8'h00, 4'b0100);
        @(posedge clk);
        #1;
        chk("b2b_end", 32'(done), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            ro = ($urandom_range(0, 3) == 0) ? 4'd10 : 4'($urandom);
            ry = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
            if (ro < 4'd6 || ro == 4'd10) ry = 8'($urandom);
            issue(ro, 8'($urandom), ry, 1'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand/result width; legal N >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request; accepted only on a cycle with ready=1.
REQ-005 SHALL have port op  input  4  operation code (REQ-013).
REQ-006 SHALL have ports a, b  input  N  operands; b is also the shift amount.
REQ-007 SHALL have port cin  input  1  carry-in, used by ADD only.
REQ-008 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result and flags are valid from this cycle.
REQ-010 SHALL have port result  output  N  registered result, held until the next completion.
REQ-011 SHALL have ports neg, zero, cout, overflow  output  1 each  registered flags, updated together with result.

Function
REQ-012 SHALL use FSM states IDLE, MUL; ready = (state==IDLE).
REQ-013 SHALL use op codes: 0 ADD a+b+cin; 1 SUB a+~b+1; 2 NOT ~a; 3 AND; 4 OR; 5 XOR; 6 SRL; 7 SLL; 8 SRA; 9 SLA; 10 MUL (low N bits of unsigned a*b); 11-15 invalid.
REQ-014 SHALL latch op, a, b and cin at the acceptance edge; later input changes SHALL NOT affect the operation in progress.
REQ-015 For ops 0-9 and invalid ops: result/flags SHALL be registered at the acceptance edge; done=1 in the following cycle; state stays IDLE; back-to-back starts SHALL give done high on consecutive cycles.
REQ-016 For MUL: IDLE->MUL at acceptance; shift-add, one partial product per cycle, iteration counter 0..N-1; after N edges in MUL, result/flags load, done=1 next cycle, MUL->IDLE; ready=0 for exactly N cycles.
REQ-017 start while ready=0 SHALL be ignored; it is neither queued nor allowed to disturb the operation in progress.
REQ-018 For all ops: neg = result[N-1]; zero = (result==0).
REQ-019 ADD: cout = carry out of bit N-1; overflow = signed overflow (operands same sign, result differs).
REQ-020 SUB: cout = carry out of a+~b+1 (1 iff a>=b unsigned); overflow = signed overflow of a-b.
REQ-021 NOT/AND/OR/XOR: cout=0, overflow=0.
REQ-022 Shifts: shamt = b as unsigned; shamt=0 -> result=a, cout=0; shamt>=N -> SRL/SLL/SLA result 0 and SRA result all a[N-1]; otherwise cout = last bit shifted out, and cout=0 when shamt>N.
REQ-023 SLA: result identical to SLL; overflow=1 iff any bit shifted through the sign position differs from a[N-1]; overflow=0 for all other shifts.
REQ-024 MUL: cout = 1 iff the upper N bits of the 2N-bit product are nonzero; overflow=0.
REQ-025 Invalid op: result=0, zero=1, neg=cout=overflow=0, done pulses as in REQ-015.
REQ-026 done SHALL never be high for two cycles due to a single accepted request.

Reset
REQ-027 On rising clk with rst_n=0: state=IDLE, counter=0, result=0, neg=zero=cout=overflow=0, done=0; hence ready=1 in the following cycle.
REQ-028 Reset during MUL SHALL abort it with no done pulse; reset SHALL take priority over a start asserted in the same cycle.

Verification (N=8)
REQ-029 ADD a=0x7F b=0x01 cin=0 -> next cycle done=1, result=0x80, neg=1, overflow=1, cout=0, zero=0.
REQ-030 SUB a=0x05 b=0x05 -> result=0x00, zero=1, cout=1; then SUB a=0x03 b=0x05 -> result=0xFE, neg=1, cout=0.
REQ-031 MUL a=0x10 b=0x11 -> ready=0 for 8 cycles, done at the 9th cycle after acceptance, result=0x10, cout=1; a start pulsed mid-MUL is ignored.
REQ-032 SRA a=0x80 b=3 -> 0xF0, cout=0; SRL a=0x81 b=1 -> 0x40, cout=1; SLA a=0x40 b=1 -> 0x80, overflow=1; SLL a=0x01 b=9 -> 0x00, zero=1.
REQ-033 rst_n=0 for one cycle during MUL iteration 4 -> no done, ready=1, result=0x00; a new ADD is then accepted normally.
REQ-034 Three back-to-back ops (AND, OR, op=12) -> done high three consecutive cycles; the third gives result=0, zero=1.
